// File: rtl/gpu_line_pkg.sv
// Shared types and helpers for the line rasteriser.
package gpu_line_pkg;

    // Widest coordinate the shared helper supports; modules narrow the result.
    localparam int unsigned ABS_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STEP
    } state_e;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/line_setup_calc.sv
// Combinational Bresenham setup: deltas, step directions, initial error and pixel count.
module line_setup_calc
    import gpu_line_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    localparam int unsigned DELTA_W = COORD_W + 1,
    localparam int unsigned ERR_W   = COORD_W + 2
) (
    input  logic [COORD_W-1:0]       x0,
    input  logic [COORD_W-1:0]       y0,
    input  logic [COORD_W-1:0]       x1,
    input  logic [COORD_W-1:0]       y1,
    input  logic                     omit_end,
    output logic [DELTA_W-1:0]       dx,
    output logic signed [DELTA_W-1:0] dy,
    output logic signed [1:0]        sx,
    output logic signed [1:0]        sy,
    output logic signed [ERR_W-1:0]  err0,
    output logic [DELTA_W-1:0]       count
);

    logic [COORD_W-1:0] adx;
    logic [COORD_W-1:0] ady;
    logic [COORD_W-1:0] span;

    assign adx  = COORD_W'(abs_diff(ABS_W'(x1), ABS_W'(x0)));
    assign ady  = COORD_W'(abs_diff(ABS_W'(y1), ABS_W'(y0)));
    assign span = (adx >= ady) ? adx : ady;

    assign dx = DELTA_W'(adx);
    // dy is kept as a non-positive value, matching the classic error-term form.
    assign dy = DELTA_W'(0) - DELTA_W'(ady);

    assign sx = (x1 > x0) ? 2'sb01 : ((x1 < x0) ? 2'sb11 : 2'sb00);
    assign sy = (y1 > y0) ? 2'sb01 : ((y1 < y0) ? 2'sb11 : 2'sb00);

    assign err0  = $signed(ERR_W'(dx)) + ERR_W'(dy);
    assign count = DELTA_W'(span) + DELTA_W'(1) - DELTA_W'(omit_end);

endmodule

// File: rtl/line_raster_gen.sv
// Bresenham line rasteriser: one command in, one pixel per cycle out on a valid/ready stream.
module line_raster_gen
    import gpu_line_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               omit_end,
    input  logic               abort,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               done
);

    localparam int unsigned DELTA_W = COORD_W + 1;
    localparam int unsigned ERR_W   = COORD_W + 2;
    localparam int unsigned E2_W    = ERR_W + 1;

    state_e state_q, state_d;

    logic [COORD_W-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic                      omit_q, omit_d;
    logic [DELTA_W-1:0]        dx_q, dx_d;
    logic signed [DELTA_W-1:0] dy_q, dy_d;
    logic signed [1:0]         sx_q, sx_d, sy_q, sy_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic [DELTA_W-1:0]        rem_q, rem_d;
    logic [COORD_W-1:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic                      pix_valid_q, pix_valid_d;
    logic                      pix_last_q, pix_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [DELTA_W-1:0]        s_dx;
    logic signed [DELTA_W-1:0] s_dy;
    logic signed [1:0]         s_sx, s_sy;
    logic signed [ERR_W-1:0]   s_err0;
    logic [DELTA_W-1:0]        s_count;

    line_setup_calc #(.COORD_W(COORD_W)) u_setup (
        .x0       (x0_q),
        .y0       (y0_q),
        .x1       (x1_q),
        .y1       (y1_q),
        .omit_end (omit_q),
        .dx       (s_dx),
        .dy       (s_dy),
        .sx       (s_sx),
        .sy       (s_sy),
        .err0     (s_err0),
        .count    (s_count)
    );

    // Error-term step: one extra bit so 2*err never wraps on full-range lines.
    logic signed [E2_W-1:0] e2, dx_e, dy_e, err_acc;
    logic                   step_x, step_y, hs;

    always_comb begin
        e2      = $signed({err_q, 1'b0});
        dx_e    = $signed(E2_W'(dx_q));
        dy_e    = E2_W'(dy_q);
        step_x  = (e2 >= dy_e);
        step_y  = (e2 <= dx_e);
        err_acc = E2_W'(err_q) + (step_x ? dy_e : E2_W'(0)) + (step_y ? dx_e : E2_W'(0));
        hs      = pix_valid_q && pix_ready;
    end

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        omit_d      = omit_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        err_d       = err_q;
        rem_d       = rem_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    omit_d  = omit_end;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    dx_d    = s_dx;
                    dy_d    = s_dy;
                    sx_d    = s_sx;
                    sy_d    = s_sy;
                    err_d   = s_err0;
                    rem_d   = s_count;
                    pix_x_d = x0_q;
                    pix_y_d = y0_q;
                    if (s_count == DELTA_W'(0)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pix_valid_d = 1'b1;
                        pix_last_d  = (s_count == DELTA_W'(1));
                        state_d     = STEP;
                    end
                end
            end
            STEP: begin
                if (hs) begin
                    err_d      = ERR_W'(err_acc);
                    pix_x_d    = step_x ? pix_x_q + COORD_W'(sx_q) : pix_x_q;
                    pix_y_d    = step_y ? pix_y_q + COORD_W'(sy_q) : pix_y_q;
                    rem_d      = rem_q - DELTA_W'(1);
                    pix_last_d = (rem_q == DELTA_W'(2));
                    if (pix_last_q) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = !abort;
                        state_d     = IDLE;
                    end
                end
                if (abort) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            omit_q      <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            err_q       <= '0;
            rem_q       <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            omit_q      <= omit_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            err_q       <= err_d;
            rem_q       <= rem_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_last  = pix_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_line_raster_gen.sv
// Directed and model-checked stimulus for line_raster_gen.
module tb_line_raster_gen;

    logic        clk = 1'b0;
    logic        reset, start, omit_end, abort, pix_ready;
    logic [15:0] x0, y0, x1, y1;
    logic        busy, pix_valid, pix_last, done;
    logic [15:0] pix_x, pix_y;

    int checks = 0;
    int errors = 0;
    int got_x[$], got_y[$], exp_x[$], exp_y[$];
    bit got_last[$];
    int done_c;

    line_raster_gen #(.COORD_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .omit_end  (omit_end),
        .abort     (abort),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; start is presented for that cycle, returns at the SETUP negedge.
    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input bit om);
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
        omit_end = om;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1 per valid cycle, 2: random ready.
    task automatic collect(input string tag, input int budget, input int mode);
        int k = 0;
        bit rdy = 1'b0;
        bit stalled = 1'b0;
        int px = 0, py = 0, pl = 0;
        got_x.delete(); got_y.delete(); got_last.delete();
        done_c = -1;
        for (int c = 1; c <= budget; c++) begin
            if (done) begin
                done_c = c;
                chk({tag, "_busy_at_done"}, int'(busy), 0);
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            pix_ready = rdy;
            if (stalled) begin
                chk({tag, "_hold_valid"}, int'(pix_valid), 1);
                chk({tag, "_hold_x"}, int'(pix_x), px);
                chk({tag, "_hold_y"}, int'(pix_y), py);
                chk({tag, "_hold_last"}, int'(pix_last), pl);
            end
            if (pix_valid) begin
                k++;
                if (rdy) begin
                    got_x.push_back(int'(pix_x));
                    got_y.push_back(int'(pix_y));
                    got_last.push_back(pix_last);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    px = int'(pix_x); py = int'(pix_y); pl = int'(pix_last);
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        pix_ready = 1'b0;
        chk({tag, "_done_seen"}, int'(done_c > 0), 1);
    endtask

    task automatic ref_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit om);
        int ddx, ddy, ssx, ssy, err, e2, n, x, y;
        exp_x.delete(); exp_y.delete();
        ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ddy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        ssx = (ax1 > ax0) ? 1 : ((ax1 < ax0) ? -1 : 0);
        ssy = (ay1 > ay0) ? 1 : ((ay1 < ay0) ? -1 : 0);
        err = ddx + ddy;
        n = ((ddx > -ddy) ? ddx : -ddy) + 1 - int'(om);
        x = ax0; y = ay0;
        for (int i = 0; i < n; i++) begin
            exp_x.push_back(x & 16'hFFFF);
            exp_y.push_back(y & 16'hFFFF);
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; x += ssx; end
            if (e2 <= ddx) begin err += ddx; y += ssy; end
        end
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, got_x.size(), exp_x.size());
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_x%0d", tag, i), got_x[i], exp_x[i]);
            chk($sformatf("%s_y%0d", tag, i), got_y[i], exp_y[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(got_last[i]), int'(i == exp_x.size() - 1));
        end
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, off;
        bit rom;
        reset = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0; omit_end = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #2;
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_last", int'(pix_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(pix_x), 0);
        chk("rst_y", int'(pix_y), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Shallow x-major line, full throughput
        start_line(0, 0, 5, 2, 1'b0);
        chk("t1_busy_setup", int'(busy), 1);
        chk("t1_valid_setup", int'(pix_valid), 0);
        collect("t1", 20, 0);
        exp_x = '{0, 1, 2, 3, 4, 5};
        exp_y = '{0, 0, 1, 1, 2, 2};
        compare("t1");
        chk("t1_done_cycle", done_c, 8);

        // Vertical up with omitted endpoint; started in the done cycle of the previous line
        start_line(3, 7, 3, 2, 1'b1);
        chk("t2_busy_after_done", int'(busy), 1);
        chk("t2_done_pulse", int'(done), 0);
        collect("t2", 20, 0);
        exp_x = '{3, 3, 3, 3, 3};
        exp_y = '{7, 6, 5, 4, 3};
        compare("t2");
        chk("t2_done_cycle", done_c, 7);

        // Diagonal with backpressure
        start_line(10, 10, 7, 13, 1'b0);
        collect("t3", 30, 1);
        exp_x = '{10, 9, 8, 7};
        exp_y = '{10, 11, 12, 13};
        compare("t3");
        chk("t3_done_cycle", done_c, 10);

        // Single point, with and without omit
        start_line(4, 4, 4, 4, 1'b0);
        collect("t4a", 10, 0);
        exp_x = '{4};
        exp_y = '{4};
        compare("t4a");
        chk("t4a_done_cycle", done_c, 3);
        start_line(4, 4, 4, 4, 1'b1);
        collect("t4b", 10, 0);
        exp_x.delete(); exp_y.delete();
        compare("t4b");
        chk("t4b_done_cycle", done_c, 2);

        // Abort after the third handshake
        start_line(0, 0, 100, 37, 1'b0);
        pix_ready = 1'b1;
        got_x.delete(); got_y.delete(); got_last.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_valid%0d", i), int'(pix_valid), 1);
            got_x.push_back(int'(pix_x));
            got_y.push_back(int'(pix_y));
        end
        chk("t5_x0", got_x[0], 0); chk("t5_y0", got_y[0], 0);
        chk("t5_x1", got_x[1], 1); chk("t5_y1", got_y[1], 0);
        chk("t5_x2", got_x[2], 2); chk("t5_y2", got_y[2], 1);
        @(negedge clk);
        pix_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_valid_after_abort", int'(pix_valid), 0);
        chk("t5_busy_after_abort", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_no_done%0d", i), int'(done), 0);
            @(negedge clk);
        end
        // New start accepted; abort while idle is ignored
        x0 = 16'd2; y0 = 16'd3; x1 = 16'd4; y1 = 16'd3; omit_end = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5_restart_busy", int'(busy), 1);
        collect("t5r", 20, 0);
        exp_x = '{2, 3, 4};
        exp_y = '{3, 3, 3};
        compare("t5r");

        // Abort coinciding with the final handshake suppresses done
        start_line(9, 9, 9, 9, 1'b0);
        @(negedge clk);
        chk("t6_valid", int'(pix_valid), 1);
        chk("t6_last", int'(pix_last), 1);
        pix_ready = 1'b1; abort = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0; abort = 1'b0;
        chk("t6_valid_off", int'(pix_valid), 0);
        chk("t6_busy_off", int'(busy), 0);
        chk("t6_no_done", int'(done), 0);
        @(negedge clk);
        chk("t6_no_done_late", int'(done), 0);

        // Start while busy is ignored and inputs may change after acceptance
        start_line(20, 5, 26, 8, 1'b0);
        x0 = 16'd1; y0 = 16'd1; x1 = 16'd2; y1 = 16'd2; omit_end = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect("t7", 60, 2);
        ref_line(20, 5, 26, 8, 1'b0);
        compare("t7");
        @(negedge clk);

        // Random short lines in every octant, random backpressure
        for (int t = 0; t < 12; t++) begin
            rx0 = int'($urandom_range(0, 65535));
            ry0 = int'($urandom_range(0, 65535));
            off = int'($urandom_range(0, 80)) - 40;
            rx1 = (rx0 + off < 0 || rx0 + off > 65535) ? rx0 - off : rx0 + off;
            off = int'($urandom_range(0, 80)) - 40;
            ry1 = (ry0 + off < 0 || ry0 + off > 65535) ? ry0 - off : ry0 + off;
            rom = 1'($urandom_range(0, 1));
            start_line(rx0, ry0, rx1, ry1, rom);
            collect($sformatf("rnd%0d", t), 300, 2);
            ref_line(rx0, ry0, rx1, ry1, rom);
            compare($sformatf("rnd%0d", t));
        end

        // Full-range line
        start_line(0, 0, 65535, 1, 1'b0);
        collect("full", 70000, 0);
        chk("full_count", got_x.size(), 65536);
        if (got_x.size() == 65536) begin
            chk("full_x32767", got_x[32767], 32767);
            chk("full_y32767", got_y[32767], 0);
            chk("full_x32768", got_x[32768], 32768);
            chk("full_y32768", got_y[32768], 1);
            chk("full_xlast", got_x[65535], 65535);
            chk("full_ylast", got_y[65535], 1);
            chk("full_lastflag", int'(got_last[65535]), 1);
            chk("full_lastflag_early", int'(got_last[65534]), 0);
        end
        chk("full_done_cycle", done_c, 65538);

        // Asynchronous reset mid-line
        start_line(7, 9, 30, 30, 1'b0);
        @(negedge clk);
        chk("t8_valid_pre", int'(pix_valid), 1);
        chk("t8_x_pre", int'(pix_x), 7);
        reset = 1'b0;
        #1;
        chk("t8_rst_valid", int'(pix_valid), 0);
        chk("t8_rst_busy", int'(busy), 0);
        chk("t8_rst_x", int'(pix_x), 0);
        chk("t8_rst_y", int'(pix_y), 0);
        chk("t8_rst_last", int'(pix_last), 0);
        chk("t8_rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_raster_gen.md
# line_raster_gen

Parametrised Bresenham line rasteriser for the SimpleGPU draw pipeline. It accepts one line command (two endpoints plus a mode bit) and emits every pixel of that line, one per cycle, over a valid/ready stream to the framebuffer writer. It handles all octants exactly with an integer error term. It adds backpressure, abort, endpoint omission for polylines, and a last-pixel marker.

## Interface
- COORD_W, 16, width of every coordinate in bits (unsigned).
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only in IDLE
- x0, y0  in  COORD_W  start endpoint, sampled on an accepted start
- x1, y1  in  COORD_W  end endpoint, sampled on an accepted start
- omit_end  in  1  1 = do not emit (x1,y1); sampled on an accepted start
- abort  in  1  synchronous cancel of the current line
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- pix_valid  out  1  pixel present on pix_x/pix_y
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready
- pix_x, pix_y  out  COORD_W  pixel coordinate
- pix_last  out  1  marks the final pixel of the line; qualified by pix_valid
- done  out  1  one-cycle pulse when a line finishes normally

## Operation
- States: IDLE, SETUP, STEP.
- IDLE: start=1 latches the inputs and moves to SETUP.
- SETUP, one cycle:
  - dx = |x1-x0| (COORD_W+1 bits).
  - dy = -|y1-y0| (signed, COORD_W+1 bits).
  - sx, sy = +1, -1, or 0 per axis.
  - err = dx+dy (signed, COORD_W+2 bits).
  - remaining = max(dx,|dy|)+1, reduced by 1 if omit_end.
  - (pix_x,pix_y) = (x0,y0).
  - If remaining==0, go to IDLE and pulse done with no pixels; otherwise go to STEP.
- STEP: pix_valid=1. pix_last=1 when remaining==1.
- On each handshake:
  - e2 = 2*err.
  - If e2 >= dy: err += dy, x += sx.
  - If e2 <= dx: err += dx, y += sy.
  - Both updates use the pre-update err.
  - remaining decrements.
  - When the handshake has pix_last=1, go to IDLE and pulse done.
- Coordinates are unsigned with modulo-2^COORD_W arithmetic. A full-range line (0 to 2^COORD_W-1) must not overflow the internal widths.
- Pixel sequence is x0,y0 first and x1,y1 last (unless omit_end). The sequence is identical for every octant and for horizontal, vertical and diagonal lines.
- A single-point line (endpoints equal) emits exactly one pixel with pix_last=1, or zero pixels with omit_end.
- abort in SETUP or STEP: go to IDLE next cycle; pix_valid drops; no done. abort in IDLE has no effect.
- abort together with a final handshake: the handshake counts, done is suppressed.
- start while not in IDLE is ignored.

## Timing
- Reset values: pix_valid=0, pix_last=0, busy=0, done=0, pix_x=0, pix_y=0, state IDLE.
- Latency: start in cycle N → SETUP in N+1 → first pix_valid in N+2.
- Throughput: 1 pixel/cycle while pix_ready=1.
- While pix_valid && !pix_ready, pix_x, pix_y and pix_last are held stable.
- pix_valid never drops without a handshake except on abort or reset.
- done and busy=0 both appear in the cycle after the final handshake. A new start is accepted in that same cycle.
- Reset asserted mid-line returns all outputs to reset values immediately.

## Structure
- Shared package gpu_line_pkg holds:
  - the state enum (IDLE, SETUP, STEP);
  - the derived widths DELTA_W = COORD_W+1 and ERR_W = COORD_W+2, as localparams computed in the module from COORD_W;
  - an abs_diff function.
- One sub-module, line_setup_calc: combinational block producing dx, dy, sx, sy, err0 and count from the endpoints and omit_end. It is registered into the main module at SETUP.

## Test plan
- (0,0)→(5,2), pix_ready=1 → pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). pix_last on (5,2). done at N+8.
- (3,7)→(3,2), omit_end=1 → (3,7),(3,6),(3,5),(3,4),(3,3), then done. (3,2) is never emitted.
- (10,10)→(7,13) with pix_ready toggling 1,0,0,1 → (10,10),(9,11),(8,12),(7,13). Outputs stable through the stalls.
- (4,4)→(4,4): with omit_end=0, exactly one pixel with pix_last=1. With omit_end=1, zero pixels and done at N+2.
- (0,0)→(100,37), abort after the 3rd handshake → pix_valid=0 the next cycle, no done, a new start is accepted.
- (0,0)→(65535,1) → 65536 pixels, last (65535,1), y steps once at x=32768. Randomised all-octant lines are compared against a reference Bresenham model.
